// File: rtl/operacao_memoria_pkg.sv
// rtl/operacao_memoria_pkg.sv - shared width default and select encodings for the memory-op datapath
package operacao_memoria_pkg;

    localparam int WIDTH_DEFAULT = 64;

    localparam logic OP_SEL_REG    = 1'b0;
    localparam logic OP_SEL_OFFSET = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/operacao_memoria_somador_subtrator.sv
// rtl/operacao_memoria_somador_subtrator.sv - ripple-carry adder/subtractor, carry-out discarded
module somador_subtrator #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s
);

    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] c;

    // Subtraction as a + ~b + 1: invert b and inject the +1 as carry-in.
    assign b_x  = b ^ {WIDTH{sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i] = a[i] ^ b_x[i] ^ c[i];
        if (i < WIDTH - 1) begin : g_carry
            assign c[i+1] = (a[i] & b_x[i]) | (a[i] & c[i]) | (b_x[i] & c[i]);
        end
    end

endmodule

// File: rtl/operacao_memoria.sv
// rtl/operacao_memoria.sv - operand select, add/sub and registered result for memory-access instructions
module operacao_memoria
    import operacao_memoria_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dinA,
    input  logic [WIDTH-1:0] dinB,
    input  logic [WIDTH-1:0] OFFSET,
    input  logic             OP_MEM,
    input  logic             ADD_SUB,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] oper_b;
    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;

    assign oper_b = (OP_MEM == OP_SEL_OFFSET) ? OFFSET : dinB;

    somador_subtrator #(
        .WIDTH(WIDTH)
    ) u_somador_subtrator (
        .a  (dinA),
        .b  (oper_b),
        .sub(ADD_SUB == OP_SUB),
        .s  (dout_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_operacao_memoria.sv
// tb/tb_operacao_memoria.sv - self-checking bench for operacao_memoria
module tb_operacao_memoria;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] dinA;
    logic [W-1:0] dinB;
    logic [W-1:0] OFFSET;
    logic         OP_MEM;
    logic         ADD_SUB;
    logic [W-1:0] dout;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] off;
        logic         op_mem;
        logic         add_sub;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    operacao_memoria #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dinA   (dinA),
        .dinB   (dinB),
        .OFFSET (OFFSET),
        .OP_MEM (OP_MEM),
        .ADD_SUB(ADD_SUB),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [W-1:0] off, input logic op_mem,
                                               input logic add_sub);
        logic [W-1:0] operand;
        operand = op_mem ? off : b;
        return add_sub ? a - operand : a + operand;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] off,
                         input logic op_mem, input logic add_sub);
        dinA    = a;
        dinB    = b;
        OFFSET  = off;
        OP_MEM  = op_mem;
        ADD_SUB = add_sub;
    endtask

    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] exp;
        logic [W-1:0] ra, rb, ro;
        logic         rm, rs;

        checks = 0;
        errors = 0;

        vecs[0] = '{64'd20, 64'd10, 64'd0, 1'b0, 1'b0, 64'd30};
        vecs[1] = '{64'd20, 64'd10, 64'd0, 1'b0, 1'b1, 64'd10};
        vecs[2] = '{64'd10, 64'd20, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6};
        vecs[3] = '{64'd20, 64'd0, 64'd5, 1'b1, 1'b0, 64'd25};
        vecs[4] = '{64'd20, 64'd999, 64'd5, 1'b1, 1'b0, 64'd25};
        vecs[5] = '{64'd20, 64'd999, 64'd5, 1'b1, 1'b1, 64'd15};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, 64'd0};
        vecs[7] = '{64'd0, 64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8] = '{64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[9] = '{64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                    64'h7FFF_FFFF_FFFF_FFFF};

        // Reset held across several edges with live operands.
        rst_n = 1'b0;
        drive(64'd20, 64'd10, 64'd0, 1'b0, 1'b0);
        #3;
        check("reset_before_edge", dout, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_after_edges", dout, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", dout, 64'd0);
        @(posedge clk);
        #1;
        check("reset_release_first_edge", dout, 64'd30);
        prev = 64'd30;

        // Directed table: value must hold until the edge, then update.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].op_mem, vecs[i].add_sub);
            #1;
            check($sformatf("vec%0d_hold", i), dout, prev);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dout, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // Mid-operation asynchronous reset pulse between edges.
        @(negedge clk);
        drive(64'd20, 64'd10, 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("midreset_pre", dout, 64'd30);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_async_clear", dout, 64'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("midreset_release_hold", dout, 64'd0);
        @(posedge clk);
        #1;
        check("midreset_recover", dout, 64'd30);
        prev = 64'd30;

        // Random vectors against the arithmetic reference model.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            ro = {$urandom, $urandom};
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            drive(ra, rb, ro, rm, rs);
            exp = ref_model(ra, rb, ro, rm, rs);
            #1;
            check($sformatf("rand%0d_hold", i), dout, prev);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", i), dout, exp);
            prev = exp;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
